// File: rtl/vga_pkg.sv
// Shared types and constants for the video line-buffer controller.
package vga_pkg;

  // IDLE: wait for frame start | PRIME: fill line 0 | RUN: windows per line | DRAIN: last-row flush
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } lb_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int BORDER_TOP    = 3;
  localparam int BORDER_BOTTOM = 2;
  localparam int BORDER_LEFT   = 1;
  localparam int BORDER_RIGHT  = 0;

  typedef struct packed {
    logic valid;
    logic top;
    logic bottom;
    logic first;
  } win_tag_t;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector for a 1-bit signal; FALLING selects the edge polarity.
module edge_detect #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign pulse = FALLING ? (prev & ~sig) : (~prev & sig);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer write/read sequencing and 3x3 window timing for a raster stream:
// buffer rotation, window-valid strobes and edge-replicate flags per frame.
module line_buffer_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 10
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              DE,
  input  logic              v_sync,
  input  logic              h_sync,
  input  logic [9:0]        x_pixel,
  output logic              lb_we,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic [1:0]        wr_sel,
  output logic              shift_en,
  output logic              win_valid,
  output logic [3:0]        border,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [9:0]        LAST_X    = 10'(H_ACTIVE - 1);
  localparam logic [8:0]        LAST_LINE = 9'(V_ACTIVE - 1);

  lb_state_e         state, state_nxt;
  logic [8:0]        line_cnt;
  logic [ADDR_W-1:0] drain_cnt;
  logic              drain_gen, drain_fin;
  win_tag_t          src, p1, p2, p3;
  logic              frame_start, line_end, h_start;
  logic              done_cond;
  logic [ADDR_W-1:0] x_sat;

  edge_detect #(.FALLING(1'b1)) u_vs_edge (.clk(pclk), .rst(reset), .sig(v_sync), .pulse(frame_start));
  edge_detect #(.FALLING(1'b1)) u_hs_edge (.clk(pclk), .rst(reset), .sig(h_sync), .pulse(h_start));
  edge_detect #(.FALLING(1'b1)) u_de_edge (.clk(pclk), .rst(reset), .sig(DE),     .pulse(line_end));

  assign x_sat = (x_pixel >= LAST_X) ? LAST_COL : ADDR_W'(x_pixel);

  // Window flags are captured when the column enters the pipe so that they
  // stay aligned with the window even after line_cnt has moved on.
  always_comb begin
    src = '0;
    case (state)
      ST_RUN:   src.valid = DE;
      ST_DRAIN: src.valid = drain_gen;
      default:  src.valid = 1'b0;
    endcase
    src.top    = (line_cnt == 9'd1);
    src.bottom = (state == ST_DRAIN);
    src.first  = src.valid & ~p1.valid;
  end

  assign done_cond   = (state == ST_DRAIN) & drain_fin & ~p1.valid & ~p2.valid & ~p3.valid;
  assign frame_done  = done_cond;
  assign frame_abort = frame_start & (state != ST_IDLE) & ~done_cond;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (frame_start)   state_nxt = ST_PRIME;
        else if (line_end) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (frame_start)                           state_nxt = ST_PRIME;
        else if (line_end && line_cnt == LAST_LINE) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_start)    state_nxt = ST_PRIME;
        else if (done_cond) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      line_cnt  <= '0;
      wr_sel    <= '0;
      drain_cnt <= '0;
      drain_gen <= 1'b0;
      drain_fin <= 1'b0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
    end else if (frame_start) begin
      line_cnt  <= '0;
      wr_sel    <= '0;
      drain_cnt <= '0;
      drain_gen <= 1'b0;
      drain_fin <= 1'b0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
    end else begin
      p1 <= src;
      p2 <= p1;
      p3 <= p2;
      if (line_end && (state == ST_PRIME || state == ST_RUN)) begin
        if (line_cnt != '1) line_cnt <= line_cnt + 9'd1;
        wr_sel <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
      end
      // Last row has no incoming line; a pseudo-DE replays the stored rows.
      if (state == ST_DRAIN) begin
        if (drain_gen) begin
          if (drain_cnt == LAST_COL) begin
            drain_gen <= 1'b0;
            drain_fin <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end else if (h_start && !drain_fin) begin
          drain_gen <= 1'b1;
          drain_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    lb_we    = 1'b0;
    lb_waddr = '0;
    lb_raddr = '0;
    case (state)
      ST_PRIME, ST_RUN: begin
        lb_we    = DE;
        lb_waddr = x_sat;
        lb_raddr = x_sat;
      end
      ST_DRAIN: lb_raddr = drain_gen ? drain_cnt : '0;
      default: ;
    endcase
  end

  assign shift_en  = p1.valid;
  assign win_valid = p3.valid;

  always_comb begin
    border                = '0;
    border[BORDER_TOP]    = p3.valid & p3.top;
    border[BORDER_BOTTOM] = p3.valid & p3.bottom;
    border[BORDER_LEFT]   = p3.valid & p3.first;
    border[BORDER_RIGHT]  = p3.valid & ~p2.valid;
  end

endmodule
